encoder_8x3: RTL and testbench

- Registered 8-to-3 binary encoder with priority resolution.
- Converts an 8-bit request vector d into the 3-bit index {a,b,c} of the asserted line.
- Used wherever a one-hot select or request bus must be compressed to a binary code.
- Flags the cases where no line is set or more than one line is set, so downstream logic can qualify the code.

---
 rtl/encoder_8x3_if.sv | 31 +++
 rtl/encoder_8x3.sv | 43 ++++
 tb/tb_encoder_8x3.sv | 138 +++++++++++++
 3 files changed

// File: rtl/encoder_8x3_if.sv
// Request/response bundle for the registered 8-to-3 priority encoder.
// The requester drives en and d; the encoder returns the code and qualifiers.
interface encoder_8x3_if;
   logic       en;
   logic [7:0] d;
   logic       a;
   logic       b;
   logic       c;
   logic       valid;
   logic       multi;

   modport master (
      output en,
      output d,
      input  a,
      input  b,
      input  c,
      input  valid,
      input  multi
   );

   modport slave (
      input  en,
      input  d,
      output a,
      output b,
      output c,
      output valid,
      output multi
   );
endinterface

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 priority encoder.
// The index of the highest set bit of d is loaded on an enabled edge.
// valid flags a non-zero word and multi flags more than one set bit.
// All outputs come straight from flops, so there is no path from d to any output.
module encoder_8x3 (
   input  logic           clk,
   input  logic           rst_n,
   encoder_8x3_if.slave   bus
);

   typedef struct packed {
      logic [2:0] code;
      logic       valid;
      logic       multi;
   } res_t;

   res_t res_nxt;
   res_t res_q;

   // Priority encode. The ascending loop lets the highest set bit win.
   // d & (d-1) clears the lowest set bit, so any remainder means more than one bit was set.
   always_comb begin
      res_nxt       = '0;
      res_nxt.valid = |bus.d;
      res_nxt.multi = |(bus.d & (bus.d - 8'd1));
      for (int i = 0; i < 8; i++) begin
         if (bus.d[i]) res_nxt.code = 3'(i);
      end
   end

   // Output register. Reset clears it asynchronously; en=0 holds it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      res_q <= '0;
      else if (bus.en) res_q <= res_nxt;
   end

   assign bus.a     = res_q.code[2];
   assign bus.b     = res_q.code[1];
   assign bus.c     = res_q.code[0];
   assign bus.valid = res_q.valid;
   assign bus.multi = res_q.multi;

endmodule

// File: tb/tb_encoder_8x3.sv
// Bench for encoder_8x3.
// Table-driven vectors feed a scoreboard queue. Hand-written sequences cover
// reset, enable hold, latency and a mid-cycle asynchronous reset.
module tb_encoder_8x3;

   typedef struct packed {
      logic [2:0] code;
      logic       valid;
      logic       multi;
   } res_t;

   typedef struct packed {
      logic [7:0] d;
      res_t       exp;
   } vec_t;

   logic clk;
   logic rst_n;
   encoder_8x3_if bus ();

   encoder_8x3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   res_t sb_q[$];

   function automatic res_t act();
      res_t r;
      r.code  = {bus.a, bus.b, bus.c};
      r.valid = bus.valid;
      r.multi = bus.multi;
      return r;
   endfunction

   task automatic chk(input string name, input res_t got, input res_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got code=%b valid=%b multi=%b, expected code=%b valid=%b multi=%b",
                  name, got.code, got.valid, got.multi, exp.code, exp.valid, exp.multi);
      end
   endtask

   // Drive one word, push its expected result, then check it one edge later.
   task automatic apply(input string name, input logic e, input logic [7:0] dv, input res_t exp);
      res_t e_res;
      bus.en = e;
      bus.d  = dv;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e_res = sb_q.pop_front();
         chk(name, act(), e_res);
      end
   endtask

   vec_t tbl[14];

   initial begin
      // One-hot sweep
      tbl[0]  = '{8'h01, '{3'd0, 1'b1, 1'b0}};
      tbl[1]  = '{8'h02, '{3'd1, 1'b1, 1'b0}};
      tbl[2]  = '{8'h04, '{3'd2, 1'b1, 1'b0}};
      tbl[3]  = '{8'h08, '{3'd3, 1'b1, 1'b0}};
      tbl[4]  = '{8'h10, '{3'd4, 1'b1, 1'b0}};
      tbl[5]  = '{8'h20, '{3'd5, 1'b1, 1'b0}};
      tbl[6]  = '{8'h40, '{3'd6, 1'b1, 1'b0}};
      tbl[7]  = '{8'h80, '{3'd7, 1'b1, 1'b0}};
      // Priority and multi-hot words
      tbl[8]  = '{8'h81, '{3'd7, 1'b1, 1'b1}};
      tbl[9]  = '{8'h0E, '{3'd3, 1'b1, 1'b1}};
      tbl[10] = '{8'hFF, '{3'd7, 1'b1, 1'b1}};
      tbl[11] = '{8'h24, '{3'd5, 1'b1, 1'b1}};
      // Zero, then d[0], which has the same code
      tbl[12] = '{8'h00, '{3'd0, 1'b0, 1'b0}};
      tbl[13] = '{8'h01, '{3'd0, 1'b1, 1'b0}};

      // Reset with all request lines high and the clock running
      rst_n  = 1'b0;
      bus.en = 1'b1;
      bus.d  = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hold", act(), '0);

      // Release reset between edges
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         apply($sformatf("vec%0d_d%02h", i, tbl[i].d), 1'b1, tbl[i].d, tbl[i].exp);
      end

      // Enable hold: load 101, then keep en low while d changes
      apply("hold_load", 1'b1, 8'h20, '{3'd5, 1'b1, 1'b0});
      for (int k = 0; k < 3; k++) begin
         apply($sformatf("hold_%0d", k), 1'b0, 8'h02, '{3'd5, 1'b1, 1'b0});
      end
      apply("hold_release", 1'b1, 8'h02, '{3'd1, 1'b1, 1'b0});

      // Latency: a change of d just after an edge must not show up before the next edge
      apply("lat_load", 1'b1, 8'h80, '{3'd7, 1'b1, 1'b0});
      bus.d = 8'h01;
      @(negedge clk);
      chk("lat_no_change", act(), '{3'd7, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      chk("lat_update", act(), '{3'd0, 1'b1, 1'b0});

      // Asynchronous reset pulsed between edges
      apply("arst_load", 1'b1, 8'hFF, '{3'd7, 1'b1, 1'b1});
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_clear", act(), '0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("arst_after_release", act(), '0);
      apply("arst_reload", 1'b1, 8'h04, '{3'd2, 1'b1, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
